uart_fifo: RTL

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo.sv
// Wishbone-attached UART with TX/RX byte FIFOs, runtime divider, parity and stop-bit options.
// Access latency is one cycle (ack follows selection); TX writes to a full FIFO and RX bytes arriving at a full FIFO are dropped.

module uart_fifo_buf #(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [7:0]                 din_i,
  input  logic                       pop_i,
  output logic [7:0]                 dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];
  // Pop is evaluated first so a full FIFO can still accept a push in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

module uart_fifo #(
  parameter logic [23:0] BASE_ADR    = 24'h300000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  logic        ack_q, irq_q;
  logic [31:0] dat_q, rd_data;
  logic [15:0] clk_div_q, eff_div;
  logic [4:0]  ctrl_q;
  logic        ovr_q, perr_q, ferr_q;
  logic        sel, acc, wr, rd;
  logic [2:0]  reg_off;

  logic          tx_push, tx_pop, tx_full, tx_empty, tx_busy;
  logic [7:0]    tx_dout;
  logic [CW-1:0] tx_cnt_unused;
  logic          rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_dout;
  logic [CW-1:0] rx_count;
  logic [8:0]    rx_cnt9;

  state_e      tx_st_q;
  logic [15:0] tx_per_q, tx_cnt_q;
  logic [7:0]  tx_sh_q;
  logic [2:0]  tx_bit_q;
  logic        tx_q, tx_par_q, tx_par_en_q, tx_two_q, tx_stop2_q, tx_end, tx_go;

  state_e      rx_st_q;
  logic [15:0] rx_per_q, rx_cnt_q, rx_tgt;
  logic [7:0]  rx_sh_q;
  logic [2:0]  rx_bit_q;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_par_en_q, rx_odd_q, rx_parbit_q;
  logic        rx_push_q, rx_perr_q, rx_ferr_q, rx_end;

  assign sel     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR);
  assign acc     = sel & ~ack_q;
  assign wr      = acc & wbs_we_i;
  assign rd      = acc & ~wbs_we_i;
  assign reg_off = wbs_adr_i[4:2];
  assign eff_div = (clk_div_q < 16'd4) ? 16'd4 : clk_div_q;
  assign tx_push = wr & (reg_off == 3'd2);
  assign rx_pop  = rd & (reg_off == 3'd3);
  assign rx_cnt9 = 9'(rx_count);
  assign tx_busy = (tx_st_q != S_IDLE);

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign tx        = tx_q;
  assign irq       = irq_q;

  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_dat_i[31:16],
                         rx_cnt9[8], tx_cnt_unused};

  always_comb begin
    rd_data = '0;
    case (reg_off)
      3'd0: rd_data = {16'h0, clk_div_q};
      3'd1: rd_data = {27'h0, ctrl_q};
      3'd3: rd_data = rx_empty ? 32'h0 : {23'h0, 1'b1, rx_dout};
      3'd4: rd_data = {16'h0, rx_cnt9[7:0], ferr_q, perr_q, ovr_q, tx_busy,
                       rx_empty, rx_full, tx_empty, tx_full};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      clk_div_q <= DEFAULT_DIV;
      ctrl_q    <= '0;
      ovr_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ack_q <= acc;
      dat_q <= rd ? rd_data : 32'h0;
      if (wr && reg_off == 3'd0) clk_div_q <= wbs_dat_i[15:0];
      if (wr && reg_off == 3'd1) ctrl_q <= wbs_dat_i[4:0];
      if (wr && reg_off == 3'd4) begin
        ovr_q  <= ovr_q & ~wbs_dat_i[5];
        perr_q <= perr_q & ~wbs_dat_i[6];
        ferr_q <= ferr_q & ~wbs_dat_i[7];
      end
      // A fresh error event wins over a same-cycle clear.
      if (rx_push_q && rx_full && !rx_pop) ovr_q <= 1'b1;
      if (rx_perr_q) perr_q <= 1'b1;
      if (rx_ferr_q) ferr_q <= 1'b1;
      irq_q <= (ctrl_q[3] & ~rx_empty) | (ctrl_q[4] & tx_empty & ~tx_busy);
    end
  end

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .push_i(tx_push), .din_i(wbs_dat_i[7:0]),
    .pop_i(tx_pop), .dout_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty),
    .count_o(tx_cnt_unused)
  );

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .push_i(rx_push_q), .din_i(rx_sh_q),
    .pop_i(rx_pop), .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty),
    .count_o(rx_count)
  );

  assign tx_end = (tx_cnt_q == tx_per_q - 16'd1);
  assign tx_go  = ~tx_empty & ((tx_st_q == S_IDLE) |
                  ((tx_st_q == S_STOP) & tx_end & (~tx_two_q | tx_stop2_q)));
  assign tx_pop = tx_go;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_st_q     <= S_IDLE;
      tx_q        <= 1'b1;
      tx_cnt_q    <= '0;
      tx_per_q    <= '0;
      tx_sh_q     <= '0;
      tx_bit_q    <= '0;
      tx_par_q    <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_two_q    <= 1'b0;
      tx_stop2_q  <= 1'b0;
    end else begin
      tx_cnt_q <= tx_end ? 16'd0 : tx_cnt_q + 16'd1;
      if (tx_go) begin
        // Frame settings are latched here so register writes only affect the next frame.
        tx_st_q     <= S_START;
        tx_q        <= 1'b0;
        tx_cnt_q    <= '0;
        tx_per_q    <= eff_div;
        tx_sh_q     <= tx_dout;
        tx_bit_q    <= '0;
        tx_par_q    <= ^tx_dout ^ ctrl_q[1];
        tx_par_en_q <= ctrl_q[0];
        tx_two_q    <= ctrl_q[2];
        tx_stop2_q  <= 1'b0;
      end else begin
        case (tx_st_q)
          S_IDLE: tx_cnt_q <= '0;
          S_START: if (tx_end) begin
            tx_st_q <= S_DATA;
            tx_q    <= tx_sh_q[0];
          end
          S_DATA: if (tx_end) begin
            if (tx_bit_q == 3'd7) begin
              tx_st_q <= tx_par_en_q ? S_PARITY : S_STOP;
              tx_q    <= tx_par_en_q ? tx_par_q : 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_sh_q  <= tx_sh_q >> 1;
              tx_q     <= tx_sh_q[1];
            end
          end
          S_PARITY: if (tx_end) begin
            tx_st_q <= S_STOP;
            tx_q    <= 1'b1;
          end
          S_STOP: if (tx_end) begin
            if (tx_two_q && !tx_stop2_q) tx_stop2_q <= 1'b1;
            else                         tx_st_q    <= S_IDLE;
          end
          default: tx_st_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_tgt = (rx_st_q == S_START) ? ({1'b0, rx_per_q[15:1]} - 16'd1) : (rx_per_q - 16'd1);
  assign rx_end = (rx_cnt_q == rx_tgt);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_st_q     <= S_IDLE;
      rx_per_q    <= '0;
      rx_cnt_q    <= '0;
      rx_sh_q     <= '0;
      rx_bit_q    <= '0;
      rx_par_en_q <= 1'b0;
      rx_odd_q    <= 1'b0;
      rx_parbit_q <= 1'b0;
      rx_push_q   <= 1'b0;
      rx_perr_q   <= 1'b0;
      rx_ferr_q   <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_push_q <= 1'b0;
      rx_perr_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      rx_cnt_q  <= rx_end ? 16'd0 : rx_cnt_q + 16'd1;
      case (rx_st_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_s2_q) begin
            rx_st_q     <= S_START;
            rx_per_q    <= eff_div;
            rx_par_en_q <= ctrl_q[0];
            rx_odd_q    <= ctrl_q[1];
          end
        end
        S_START: if (rx_end) begin
          rx_st_q  <= rx_s2_q ? S_IDLE : S_DATA;
          rx_bit_q <= '0;
        end
        S_DATA: if (rx_end) begin
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_q <= rx_par_en_q ? S_PARITY : S_STOP;
        end
        S_PARITY: if (rx_end) begin
          rx_parbit_q <= rx_s2_q;
          rx_st_q     <= S_STOP;
        end
        S_STOP: if (rx_end) begin
          rx_st_q <= S_IDLE;
          if (!rx_s2_q)                                                  rx_ferr_q <= 1'b1;
          else if (rx_par_en_q && (rx_parbit_q != (^rx_sh_q ^ rx_odd_q))) rx_perr_q <= 1'b1;
          else                                                           rx_push_q <= 1'b1;
        end
        default: rx_st_q <= S_IDLE;
      endcase
    end
  end
endmodule
